// File: rtl/indicator_pkg.sv
// rtl/indicator_pkg.sv - shared state encoding and defaults for the turn-indicator controller
package indicator_pkg;

    localparam int CLK_FREQ_HZ = 50_000_000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } ind_state_t;

endpackage

// File: rtl/indicator_debounce.sv
// rtl/indicator_debounce.sv - 2-FF synchroniser plus stable-count debouncer for one raw button
module indicator_debounce #(
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;

    // Counter only runs while the synced level disagrees with the accepted one.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        cnt_d   = '0;
        dout_d  = dout_q;
        if (sync2_q != dout_q) begin
            if (cnt_q == CNT_LAST) begin
                dout_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/indicator_ctrl.sv
// rtl/indicator_ctrl.sv - indicator FSM with shared blink timer and hazard priority
// Optional minimum-flash (comfort) behaviour under INDICATOR_COMFORT_EN.
module indicator_ctrl
    import indicator_pkg::*;
#(
    parameter int HALF_PERIOD_CYC = 25_000_000,
    parameter int DEBOUNCE_CYC    = 500_000,
    parameter int COMFORT_FLASHES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_hazard,
    output logic       left_ind,
    output logic       right_ind,
    output logic [1:0] mode
);

    localparam int CNT_W = $clog2(HALF_PERIOD_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD_CYC - 1);

    logic l_db, r_db, h_db;

    indicator_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_left (
        .clk (clk), .rst (rst), .din (btn_left), .dout (l_db)
    );
    indicator_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_right (
        .clk (clk), .rst (rst), .din (btn_right), .dout (r_db)
    );
    indicator_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_hazard (
        .clk (clk), .rst (rst), .din (btn_hazard), .dout (h_db)
    );

    ind_state_t       state_q, state_d;
    ind_state_t       req;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             left_ind_q, left_ind_d;
    logic             right_ind_q, right_ind_d;
    logic             restart;
    logic             end_on;

    always_comb begin
        req = IDLE;
        if (h_db) begin
            req = HAZARD;
        end else if (l_db && !r_db) begin
            req = LEFT;
        end else if (r_db && !l_db) begin
            req = RIGHT;
        end
    end

    assign end_on = (state_q != IDLE) && (cnt_q == CNT_LAST) && phase_q;

`ifdef INDICATOR_COMFORT_EN
    localparam logic [3:0] FLASH_TGT  = 4'(COMFORT_FLASHES);
    localparam logic [3:0] FLASH_LAST = 4'(COMFORT_FLASHES - 1);

    logic [3:0] flash_q, flash_d;
    logic       dir_active;

    assign dir_active = (state_q == LEFT) || (state_q == RIGHT);

    // A released direction keeps blinking until its last guaranteed ON phase ends.
    always_comb begin
        state_d = req;
        if (req == IDLE && dir_active && flash_q < FLASH_TGT &&
            !(end_on && flash_q == FLASH_LAST)) begin
            state_d = state_q;
        end
    end

    always_comb begin
        flash_d = flash_q;
        if (restart || state_d == IDLE) begin
            flash_d = '0;
        end else if (end_on && dir_active && flash_q != FLASH_TGT) begin
            flash_d = flash_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flash_q <= '0;
        end else begin
            flash_q <= flash_d;
        end
    end
`else
    always_comb begin
        state_d = req;
    end
`endif

    assign restart = (state_d != IDLE) && (state_d != state_q);

    // Lamps are derived from the next state/phase so they move with mode.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (state_d == IDLE) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
        end
        left_ind_d  = phase_d && (state_d == LEFT  || state_d == HAZARD);
        right_ind_d = phase_d && (state_d == RIGHT || state_d == HAZARD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            left_ind_q  <= 1'b0;
            right_ind_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            left_ind_q  <= left_ind_d;
            right_ind_q <= right_ind_d;
        end
    end

    assign left_ind  = left_ind_q;
    assign right_ind = right_ind_q;
    assign mode      = state_q;

endmodule

// File: tb/tb_indicator_ctrl.sv
// tb/tb_indicator_ctrl.sv - scoreboard bench for indicator_ctrl with per-scenario tasks
module tb_indicator_ctrl;

    localparam int HP  = 8;
    localparam int DB  = 4;
    localparam int CF  = 3;
    localparam int LAT = 3 + DB;
`ifdef INDICATOR_COMFORT_EN
    localparam bit COMFORT = 1'b1;
`else
    localparam bit COMFORT = 1'b0;
`endif
    localparam int COMFORT_END = LAT + (2 * CF - 1) * HP;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_hazard = 1'b0;
    logic       left_ind;
    logic       right_ind;
    logic [1:0] mode;

    indicator_ctrl #(
        .HALF_PERIOD_CYC (HP),
        .DEBOUNCE_CYC    (DB),
        .COMFORT_FLASHES (CF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_hazard (btn_hazard),
        .left_ind   (left_ind),
        .right_ind  (right_ind),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       l;
        logic       r;
        logic [1:0] m;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic obs_t mk(input logic l, input logic r, input logic [1:0] m);
        mk = {l, r, m};
    endfunction

    function automatic logic on(input int k, input int s);
        on = (k >= s) && (((k - s) / HP) % 2 == 0);
    endfunction

    // Expected trace of a left/right tap of length t starting at k=0.
    function automatic logic tap_active(input int k, input int t);
        if (COMFORT && t < HP) tap_active = (k >= LAT) && (k < COMFORT_END);
        else                   tap_active = (k >= LAT) && (k < LAT + t);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, want;
        btn_left = 1'b0; btn_right = 1'b0; btn_hazard = 1'b0;
        rst = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 2'd0));
        tick();
        tick();
        got = {left_ind, right_ind, mode}; want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++; $display("FAIL reset_held got=%b want=%b", got, want);
        end
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(mk(1'b0, 1'b0, 2'd0));
            tick();
            got = {left_ind, right_ind, mode}; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL reset_idle k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    task automatic test_left_hold();
        obs_t got, want;
        btn_left = 1'b1;
        for (int k = 1; k <= 66; k++) begin
            if (k - 1 == 56) btn_left = 1'b0;
            if (k >= LAT && k < 63) exp_q.push_back(mk(on(k, LAT), 1'b0, 2'd1));
            else                    exp_q.push_back(mk(1'b0, 1'b0, 2'd0));
            tick();
            got = {left_ind, right_ind, mode}; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL left_hold k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    task automatic test_right_glitch_and_tap();
        obs_t got, want;
        btn_right = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            if (k - 1 == 3) btn_right = 1'b0;
            exp_q.push_back(mk(1'b0, 1'b0, 2'd0));
            tick();
            got = {left_ind, right_ind, mode}; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL right_glitch k=%0d got=%b want=%b", k, got, want);
            end
        end
        btn_right = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            if (k - 1 == 5) btn_right = 1'b0;
            if (tap_active(k, 5)) exp_q.push_back(mk(1'b0, on(k, LAT), 2'd2));
            else                  exp_q.push_back(mk(1'b0, 1'b0, 2'd0));
            tick();
            got = {left_ind, right_ind, mode}; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL right_tap k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    task automatic test_hazard_override();
        obs_t got, want;
        btn_left = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            if (k - 1 == 18) btn_hazard = 1'b1;
            if (k - 1 == 30) btn_hazard = 1'b0;
            if (k < LAT)      exp_q.push_back(mk(1'b0, 1'b0, 2'd0));
            else if (k < 25)  exp_q.push_back(mk(on(k, LAT), 1'b0, 2'd1));
            else if (k < 37)  exp_q.push_back(mk(on(k, 25), on(k, 25), 2'd3));
            else              exp_q.push_back(mk(on(k, 37), 1'b0, 2'd1));
            tick();
            got = {left_ind, right_ind, mode}; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL hazard_override k=%0d got=%b want=%b", k, got, want);
            end
        end
        btn_left = 1'b0;
    endtask

    task automatic test_both_and_switch();
        obs_t got, want;
        btn_left = 1'b1; btn_right = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            exp_q.push_back(mk(1'b0, 1'b0, 2'd0));
            tick();
            got = {left_ind, right_ind, mode}; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL both_pressed k=%0d got=%b want=%b", k, got, want);
            end
        end
        test_reset();
        btn_left = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            if (k - 1 == 10) begin
                btn_left = 1'b0; btn_right = 1'b1;
            end
            if (k < LAT)      exp_q.push_back(mk(1'b0, 1'b0, 2'd0));
            else if (k < 17)  exp_q.push_back(mk(on(k, LAT), 1'b0, 2'd1));
            else              exp_q.push_back(mk(1'b0, on(k, 17), 2'd2));
            tick();
            got = {left_ind, right_ind, mode}; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL left_to_right k=%0d got=%b want=%b", k, got, want);
            end
        end
        btn_right = 1'b0;
    endtask

    task automatic test_left_tap();
        obs_t got, want;
        btn_left = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            if (k - 1 == 6) btn_left = 1'b0;
            if (tap_active(k, 6)) exp_q.push_back(mk(on(k, LAT), 1'b0, 2'd1));
            else                  exp_q.push_back(mk(1'b0, 1'b0, 2'd0));
            tick();
            got = {left_ind, right_ind, mode}; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL left_tap k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_hazard();
        obs_t got, want;
        btn_hazard = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (k >= LAT) exp_q.push_back(mk(on(k, LAT), on(k, LAT), 2'd3));
            else          exp_q.push_back(mk(1'b0, 1'b0, 2'd0));
            tick();
            got = {left_ind, right_ind, mode}; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL hazard_pre_rst k=%0d got=%b want=%b", k, got, want);
            end
        end
        rst = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 2'd0));
        #1;
        got = {left_ind, right_ind, mode}; want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++; $display("FAIL async_rst got=%b want=%b", got, want);
        end
        tick();
        rst = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            if (j >= LAT) exp_q.push_back(mk(on(j, LAT), on(j, LAT), 2'd3));
            else          exp_q.push_back(mk(1'b0, 1'b0, 2'd0));
            tick();
            got = {left_ind, right_ind, mode}; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL hazard_post_rst j=%0d got=%b want=%b", j, got, want);
            end
        end
        btn_hazard = 1'b0;
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_left_hold();
        test_reset();
        test_right_glitch_and_tap();
        test_reset();
        test_hazard_override();
        test_reset();
        test_both_and_switch();
        test_reset();
        test_left_tap();
        test_reset();
        test_reset_mid_hazard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/indicator_ctrl.md
# indicator_ctrl

Parametrised turn-indicator controller for the RC car: drives left and right indicator lamps from three raw push-buttons (left, right, hazard). Provides synchronisation, debouncing, a single shared blink timer with phase restart on mode change, and hazard priority. Sits between the board button inputs and the lamp LEDs/GPIO, replacing the per-button free-running toggle logic.

## Interface
- `HALF_PERIOD_CYC`, default 25_000_000: clock cycles per lamp ON or OFF phase (0.5 s at 50 MHz). Must be ≥ 2.
- `DEBOUNCE_CYC`, default 500_000: consecutive stable cycles required before a button change is accepted (10 ms). Must be ≥ 1.
- `COMFORT_FLASHES`, default 3: ON phases guaranteed per left/right activation. Used only with `INDICATOR_COMFORT_EN`. Range 1..15.
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `btn_left` in 1: raw left request, active-high level, asynchronous to `clk`.
- `btn_right` in 1: raw right request, active-high level, asynchronous.
- `btn_hazard` in 1: raw hazard request, active-high level, asynchronous.
- `left_ind` out 1: left lamp, registered.
- `right_ind` out 1: right lamp, registered.
- `mode` out 2: current state code (IDLE=0, LEFT=1, RIGHT=2, HAZARD=3), registered.

## Operation
- Each button passes through a 2-FF synchroniser, then a debouncer. The debounced value flips only after the synced value has differed from it for `DEBOUNCE_CYC` consecutive cycles. Any agreement resets the debounce count.
- FSM states: IDLE, LEFT, RIGHT, HAZARD. The next state is evaluated every cycle from the debounced levels `L`, `R`, `H`:
  - `H`=1 → HAZARD. Hazard overrides everything.
  - else `L`=1, `R`=0 → LEFT.
  - else `R`=1, `L`=0 → RIGHT.
  - else (both high, or both low) → IDLE. Both high without hazard is treated as no request.
- Blink timer `cnt`, width `$clog2(HALF_PERIOD_CYC)`, plus a `phase` bit:
  - In IDLE: `cnt`=0, `phase`=0.
  - Otherwise `cnt` increments each cycle. At `cnt`==`HALF_PERIOD_CYC`-1 it wraps to 0 and `phase` toggles.
- Phase restart: on any transition into a non-IDLE state from a different state (including LEFT↔RIGHT and into or out of HAZARD), `cnt`←0 and `phase`←1. The lamp is therefore ON immediately.
- Lamp outputs:
  - LEFT: `left_ind`=`phase`, `right_ind`=0.
  - RIGHT: `right_ind`=`phase`, `left_ind`=0.
  - HAZARD: both lamps = `phase`, always in sync.
  - IDLE: both 0.
- Reset: state IDLE; `cnt`=0; `phase`=0; `left_ind`=0, `right_ind`=0, `mode`=0; debouncer outputs 0; debounce counts 0; synchronisers 0.
- Reset asserted mid-blink clears everything asynchronously. After release, the block re-qualifies still-held buttons through the full debounce before any lamp lights.

## Timing
- Button edge to debounced edge: 2 + `DEBOUNCE_CYC` cycles, for an input held stable.
- Debounced edge to `mode`/lamp update: 1 cycle.
- Total press-to-lamp-ON: 3 + `DEBOUNCE_CYC` cycles.
- Blink period: 2·`HALF_PERIOD_CYC` cycles with exactly 50 % duty. The first ON phase lasts a full `HALF_PERIOD_CYC`.
- Release of the request (comfort feature off): lamp off and `mode`=0 one cycle after the debounced fall.
- Glitches shorter than `DEBOUNCE_CYC` cycles produce no output change.

## Configuration
- `INDICATOR_COMFORT_EN` defined:
  - A 4-bit counter counts completed ON phases in LEFT/RIGHT.
  - If `L`/`R` falls before `COMFORT_FLASHES` ON phases have completed, the state holds and blinking continues. It returns to IDLE at the ON→OFF transition ending the `COMFORT_FLASHES`-th ON phase.
  - The counter clears on every phase restart.
  - The opposite direction or hazard during comfort blinking takes over immediately with a phase restart.
  - Release after `COMFORT_FLASHES` is reached behaves as without the macro.
- Undefined: no flash counter. Release → IDLE as specified in Timing.

## Structure
- `indicator_pkg`:
  - `typedef enum logic [1:0] ind_state_t` {IDLE, LEFT, RIGHT, HAZARD}, whose encoding is `mode`.
  - `localparam` for the default clock frequency.
- Sub-module `indicator_debounce`:
  - parameter `DEBOUNCE_CYC`
  - ports `clk`, `rst`, `din`, `dout`
  - contains the synchroniser and debounce counter
  - instantiated three times.
- FSM, blink timer and comfort counter live in `indicator_ctrl`.

## Test plan
Bench parameters: `HALF_PERIOD_CYC`=8, `DEBOUNCE_CYC`=4, `COMFORT_FLASHES`=3.

1. Hold `btn_left` → `left_ind` rises 7 cycles after the press, then toggles every 8 cycles. `right_ind` stays 0 and `mode`=1.
2. Pulse `btn_right` for 3 cycles → no output change and `mode` stays 0. Hold it for 5 cycles without the macro → `right_ind` is high for exactly 5 cycles.
3. Blink LEFT, then assert `btn_hazard` mid-OFF-phase → 7 cycles later both lamps are 1 together with `mode`=3. Release hazard while `L` is held → LEFT with a phase restart (lamp ON immediately).
4. Press `btn_left` and `btn_right` together → `mode` stays 0 and lamps stay 0. Switch from LEFT to RIGHT → `right_ind`=1 on the switch cycle, `left_ind`=0.
5. With `INDICATOR_COMFORT_EN`, a 6-cycle tap of `btn_left` → exactly 3 ON pulses of 8 cycles, then `mode`=0.
6. Assert `rst` mid-HAZARD for 1 cycle → all outputs 0 immediately. With hazard still held, the lamps return 7 cycles after release.
